// File: rtl/adc_ctrl_pkg.sv
// Shared types and constants for the ADC register-port scheduler.
package adc_ctrl_pkg;

  localparam int DATA_W = 16;

  localparam logic [7:0] ADC_ADDR_TEMP = 8'h40;
  localparam logic [7:0] ADC_ADDR_VCC  = 8'h41;

  typedef logic [DATA_W-1:0] adc_word_t;

  // Single-transaction sequencing states.
  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    WAIT,
    DONE
  } txn_state_e;

endpackage

// File: rtl/adc_poll_sched_if.sv
// ADC read port plus host read port, bundled for the scheduler.
// master = scheduler side, slave = ADC wrapper / host side.
interface adc_poll_sched_if;
  import adc_ctrl_pkg::*;

  logic [7:0] adc_daddr;
  logic       adc_secen;
  adc_word_t  adc_do;
  logic       adc_drdy;

  logic       host_req;
  logic [7:0] host_addr;
  logic       host_ack;
  adc_word_t  host_rdata;
  logic       host_err;

  modport master (
    output adc_daddr, adc_secen, host_ack, host_rdata, host_err,
    input  adc_do, adc_drdy, host_req, host_addr
  );

  modport slave (
    input  adc_daddr, adc_secen, host_ack, host_rdata, host_err,
    output adc_do, adc_drdy, host_req, host_addr
  );

endinterface

// File: rtl/adc_drp_txn.sv
// One ADC register read: address setup, one-cycle strobe, wait for data
// ready with a timeout, then a one-cycle DONE carrying the result.
module adc_drp_txn
  import adc_ctrl_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = ADC_ADDR_TEMP,
  parameter int         TIMEOUT   = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] addr,
  output logic       done,
  output logic       ok,
  output adc_word_t  data,
  output logic       busy,
  output logic [7:0] adc_daddr,
  output logic       adc_secen,
  input  adc_word_t  adc_do,
  input  logic       adc_drdy
);

  localparam logic [15:0] TMO = 16'(TIMEOUT);

  txn_state_e  state;
  logic [15:0] wait_cnt;

  // Transaction sequencer; all port-facing outputs are registered.
  // adc_daddr is only loaded on start, so it holds between transactions.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      adc_daddr <= BASE_ADDR;
      adc_secen <= 1'b0;
      done      <= 1'b0;
      ok        <= 1'b0;
      data      <= '0;
      wait_cnt  <= '0;
    end else begin
      adc_secen <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= SETUP;
            adc_daddr <= addr;
          end
        end
        SETUP: begin
          state     <= STROBE;
          adc_secen <= 1'b1;
        end
        STROBE: begin
          state    <= WAIT;
          wait_cnt <= '0;
        end
        WAIT: begin
          // Data ready on the timeout cycle still counts as success.
          if (adc_drdy) begin
            state <= DONE;
            done  <= 1'b1;
            ok    <= 1'b1;
            data  <= adc_do;
          end else if (wait_cnt == TMO) begin
            state <= DONE;
            done  <= 1'b1;
            ok    <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: rtl/adc_poll_sched.sv
// Shares the ADC read port between a periodic channel scan and host reads.
// Keeps a shadow bank of the latest channel values.
module adc_poll_sched
  import adc_ctrl_pkg::*;
#(
  parameter int         NUM_CH    = 4,
  parameter logic [7:0] BASE_ADDR = ADC_ADDR_TEMP,
  parameter int         POLL_DIV  = 1024,
  parameter int         TIMEOUT   = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  adc_poll_sched_if.master         drp,
  output logic [DATA_W*NUM_CH-1:0] ch_data,
  output logic [NUM_CH-1:0]        ch_valid,
  output logic                     scan_overrun,
  output logic                     busy
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TMR_W = $clog2(POLL_DIV);

  logic [TMR_W-1:0]               poll_tmr;
  logic                           poll_wrap;
  logic                           poll_pending;
  logic [IDX_W-1:0]               scan_idx;
  logic                           last_ch;
  logic                           cur_host;
  logic                           start;
  logic [7:0]                     sel_addr;
  logic                           txn_busy;
  logic                           txn_done;
  logic                           txn_ok;
  adc_word_t                      txn_data;
  logic                           scan_done;
  logic                           host_done;
  logic [NUM_CH-1:0][DATA_W-1:0]  shadow;
  adc_word_t                      rdata_q;
  logic                           err_q;

  adc_drp_txn #(
    .BASE_ADDR (BASE_ADDR),
    .TIMEOUT   (TIMEOUT)
  ) u_txn (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .addr      (sel_addr),
    .done      (txn_done),
    .ok        (txn_ok),
    .data      (txn_data),
    .busy      (txn_busy),
    .adc_daddr (drp.adc_daddr),
    .adc_secen (drp.adc_secen),
    .adc_do    (drp.adc_do),
    .adc_drdy  (drp.adc_drdy)
  );

  assign poll_wrap = (poll_tmr == TMR_W'(POLL_DIV - 1));
  assign last_ch   = (scan_idx == IDX_W'(NUM_CH - 1));
  assign scan_done = txn_done && !cur_host;
  assign host_done = txn_done && cur_host;

  // Free-running poll timer.
  always_ff @(posedge clk) begin
    if (rst) poll_tmr <= '0;
    else     poll_tmr <= poll_wrap ? '0 : poll_tmr + 1'b1;
  end

  // Arbitration only while the sequencer is idle; host beats the scan.
  always_comb begin
    start    = !txn_busy && (drp.host_req || poll_pending);
    sel_addr = drp.host_req ? drp.host_addr : BASE_ADDR + 8'(scan_idx);
  end

  // Remember who owns the transaction in flight.
  always_ff @(posedge clk) begin
    if (rst)        cur_host <= 1'b0;
    else if (start) cur_host <= drp.host_req;
  end

  // Scan progress, round request and sticky overrun. A wrap that lands on
  // the last channel's completion re-arms the scan rather than dropping it.
  always_ff @(posedge clk) begin
    if (rst) begin
      poll_pending <= 1'b0;
      scan_overrun <= 1'b0;
      scan_idx     <= '0;
    end else begin
      if (scan_done) scan_idx <= last_ch ? '0 : scan_idx + 1'b1;
      if (poll_wrap) begin
        poll_pending <= 1'b1;
        if (poll_pending) scan_overrun <= 1'b1;
      end else if (scan_done && last_ch) begin
        poll_pending <= 1'b0;
      end
    end
  end

  // Shadow bank: a timeout keeps the old value but marks it stale.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow   <= '0;
      ch_valid <= '0;
    end else if (scan_done) begin
      if (txn_ok) shadow[scan_idx] <= txn_data;
      ch_valid[scan_idx] <= txn_ok;
    end
  end

  // Held copy of the last host result, shown after the ack cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (host_done) begin
      if (txn_ok) rdata_q <= txn_data;
      err_q <= !txn_ok;
    end
  end

  // Ack cycle shows the fresh result directly so data is valid with the ack.
  assign drp.host_ack   = host_done;
  assign drp.host_rdata = (host_done && txn_ok) ? txn_data : rdata_q;
  assign drp.host_err   = host_done ? !txn_ok : err_q;

  assign ch_data = shadow;
  assign busy    = txn_busy;

endmodule

// File: tb/tb_adc_poll_sched.sv
// Directed bench: host reads, scan rounds, arbitration order, timeouts,
// overrun and reset behaviour against two differently tuned instances.
module tb_adc_poll_sched;
  import adc_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  adc_poll_sched_if a ();
  adc_poll_sched_if b ();

  logic [63:0] ch_data_a, ch_data_b;
  logic [3:0]  ch_valid_a, ch_valid_b;
  logic        ovr_a, ovr_b, busy_a, busy_b;

  adc_poll_sched #(.NUM_CH(4), .BASE_ADDR(8'h40), .POLL_DIV(64), .TIMEOUT(8)) dut_a (
    .clk(clk), .rst(rst), .drp(a), .ch_data(ch_data_a), .ch_valid(ch_valid_a),
    .scan_overrun(ovr_a), .busy(busy_a));

  adc_poll_sched #(.NUM_CH(4), .BASE_ADDR(8'h40), .POLL_DIV(16), .TIMEOUT(255)) dut_b (
    .clk(clk), .rst(rst_b), .drp(b), .ch_data(ch_data_b), .ch_valid(ch_valid_b),
    .scan_overrun(ovr_b), .busy(busy_b));

  // ADC model A: data ready dly_a cycles after the strobe, value 1000+addr.
  int          dly_a = 2;
  bit          mute41 = 1'b0;
  bit          use_ovr = 1'b0;
  int          left_a = 0;
  logic [7:0]  addr_a = 8'h00;
  logic [7:0]  strobe_log[$];
  int          acks_a = 0;

  always @(posedge clk) begin
    a.adc_drdy <= 1'b0;
    a.adc_do   <= 16'hDEAD;
    if (a.adc_secen) begin
      strobe_log.push_back(a.adc_daddr);
      addr_a <= a.adc_daddr;
      left_a <= dly_a - 1;
    end else if (left_a == 1) begin
      left_a <= 0;
      if (!(mute41 && addr_a == 8'h41)) begin
        a.adc_drdy <= 1'b1;
        a.adc_do   <= use_ovr ? 16'h0A5B : 16'h1000 + {8'h00, addr_a};
      end
    end else if (left_a > 1) begin
      left_a <= left_a - 1;
    end
  end

  always @(posedge clk) if (a.host_ack === 1'b1) acks_a <= acks_a + 1;

  // ADC model B: slow, data ready 10 cycles after the strobe, value 2000+addr.
  int         left_b = 0;
  logic [7:0] addr_b = 8'h00;

  always @(posedge clk) begin
    b.adc_drdy <= 1'b0;
    b.adc_do   <= 16'hDEAD;
    if (b.adc_secen) begin
      addr_b <= b.adc_daddr;
      left_b <= 9;
    end else if (left_b == 1) begin
      left_b     <= 0;
      b.adc_drdy <= 1'b1;
      b.adc_do   <= 16'h2000 + {8'h00, addr_b};
    end else if (left_b > 1) begin
      left_b <= left_b - 1;
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Raise a host read in the current (idle) cycle; return the ack cycle index.
  task automatic host_read(input logic [7:0] addr, input int limit, output int lat);
    a.host_addr = addr;
    a.host_req  = 1'b1;
    step();
    lat = 1;
    while (a.host_ack !== 1'b1 && lat < limit) begin
      step();
      lat++;
    end
  endtask

  logic [7:0] exp_order [5] = '{8'h40, 8'h41, 8'h4A, 8'h42, 8'h43};

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int acks0;
    a.host_req = 1'b0; a.host_addr = 8'h40;
    b.host_req = 1'b0; b.host_addr = 8'h40;
    step(3);

    // Reset state.
    chk("rst_daddr", a.adc_daddr, 8'h40);
    chk("rst_secen", a.adc_secen, 0);
    chk("rst_ack", a.host_ack, 0);
    chk("rst_rdata", a.host_rdata, 0);
    chk("rst_err", a.host_err, 0);
    chk("rst_chdata", ch_data_a, 0);
    chk("rst_chvalid", ch_valid_a, 0);
    chk("rst_ovr", ovr_a, 0);
    chk("rst_busy", busy_a, 0);
    rst = 1'b0; rst_b = 1'b0;
    step();

    // Host read, data ready 2 cycles after strobe.
    dly_a = 2; use_ovr = 1'b1;
    a.host_addr = 8'h40; a.host_req = 1'b1;
    chk("t1_c0_busy", busy_a, 0);
    step();
    chk("t1_c1_busy", busy_a, 1);
    chk("t1_c1_daddr", a.adc_daddr, 8'h40);
    chk("t1_c1_secen", a.adc_secen, 0);
    step();
    chk("t1_c2_secen", a.adc_secen, 1);
    chk("t1_c2_daddr", a.adc_daddr, 8'h40);
    step();
    chk("t1_c3_secen", a.adc_secen, 0);
    step();
    chk("t1_c4_ack", a.host_ack, 0);
    step();
    chk("t1_c5_ack", a.host_ack, 1);
    chk("t1_c5_rdata", a.host_rdata, 16'h0A5B);
    chk("t1_c5_err", a.host_err, 0);
    a.host_req = 1'b0; use_ovr = 1'b0;
    step();
    chk("t1_c6_ack", a.host_ack, 0);
    chk("t1_c6_rdata", a.host_rdata, 16'h0A5B);
    chk("t1_c6_busy", busy_a, 0);

    // Data ready on the very cycle the counter reaches TIMEOUT: success.
    dly_a = 9;
    host_read(8'h42, 40, lat);
    chk("edge_ok_lat", lat, 12);
    chk("edge_ok_err", a.host_err, 0);
    chk("edge_ok_rdata", a.host_rdata, 16'h1042);
    a.host_req = 1'b0;
    step();

    // One cycle later: timeout, rdata unchanged, late ready ignored.
    dly_a = 10;
    host_read(8'h43, 40, lat);
    chk("edge_tmo_lat", lat, 12);
    chk("edge_tmo_err", a.host_err, 1);
    chk("edge_tmo_rdata", a.host_rdata, 16'h1042);
    a.host_req = 1'b0;
    step();
    chk("edge_tmo_hold", a.host_rdata, 16'h1042);
    dly_a = 2;

    // First scan round.
    lat = 0;
    while (ch_valid_a !== 4'hF && lat < 150) begin step(); lat++; end
    chk("scan1_valid", ch_valid_a, 4'hF);
    for (int i = 0; i < 4; i++) chk("scan1_data", ch_data_a[16*i +: 16], 16'h1040 + i);

    // Host request inserted during channel 1 WAIT of the next round.
    strobe_log.delete();
    lat = 0;
    while (!(a.adc_secen === 1'b1 && a.adc_daddr === 8'h41) && lat < 120) begin step(); lat++; end
    chk("il_ch1_strobe", {a.adc_secen, a.adc_daddr}, 9'h141);
    step();
    host_read(8'h4A, 60, lat);
    chk("il_ack", a.host_ack, 1);
    chk("il_rdata", a.host_rdata, 16'h104A);
    chk("il_err", a.host_err, 0);
    a.host_req = 1'b0;
    lat = 0;
    while (strobe_log.size() < 5 && lat < 60) begin step(); lat++; end
    chk("il_count", strobe_log.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < strobe_log.size()) chk("il_order", strobe_log[i], exp_order[i]);
    step(10);

    // Channel 1 never answers: stale flag, value kept, scan carries on.
    mute41 = 1'b1;
    lat = 0;
    while (ch_valid_a !== 4'hD && lat < 200) begin step(); lat++; end
    chk("tmo_scan_valid", ch_valid_a, 4'hD);
    step(20);
    chk("tmo_scan_valid2", ch_valid_a, 4'hD);
    chk("tmo_scan_keep", ch_data_a[31:16], 16'h1041);
    chk("tmo_scan_next", ch_data_a[47:32], 16'h1042);
    host_read(8'h41, 60, lat);
    chk("tmo_host_ack", a.host_ack, 1);
    chk("tmo_host_err", a.host_err, 1);
    chk("tmo_host_rdata", a.host_rdata, 16'h104A);
    a.host_req = 1'b0;
    step();

    // One-cycle reset clears the bank and host result.
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst2_busy", busy_a, 0);
    chk("rst2_valid", ch_valid_a, 0);
    chk("rst2_rdata", a.host_rdata, 0);
    chk("rst2_daddr", a.adc_daddr, 8'h40);
    step(3);

    // Reset in the cycle after the strobe: no ack, late ready ignored.
    dly_a = 4; mute41 = 1'b0;
    a.host_addr = 8'h41; a.host_req = 1'b1;
    step(2);
    chk("mid_strobe", a.adc_secen, 1);
    acks0 = acks_a;
    step();
    rst = 1'b1; a.host_req = 1'b0;
    step();
    rst = 1'b0;
    chk("mid_busy", busy_a, 0);
    chk("mid_ack", a.host_ack, 0);
    chk("mid_daddr", a.adc_daddr, 8'h40);
    step(6);
    chk("mid_no_ack", acks_a, acks0);
    chk("mid_rdata", a.host_rdata, 0);
    chk("mid_busy_late", busy_a, 0);

    // Slow model against a short poll period.
    chk("b_overrun", ovr_b, 1);
    chk("b_valid", ch_valid_b, 4'hF);
    chk("b_data0", ch_data_b[15:0], 16'h2040);
    step(40);
    chk("b_overrun_sticky", ovr_b, 1);
    rst_b = 1'b1;
    step();
    rst_b = 1'b0;
    chk("b_rst_daddr", b.adc_daddr, 8'h40);
    chk("b_rst_secen", b.adc_secen, 0);
    chk("b_rst_ack", b.host_ack, 0);
    chk("b_rst_rdata", b.host_rdata, 0);
    chk("b_rst_err", b.host_err, 0);
    chk("b_rst_chdata", ch_data_b, 0);
    chk("b_rst_chvalid", ch_valid_b, 0);
    chk("b_rst_ovr", ovr_b, 0);
    chk("b_rst_busy", busy_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
